// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC register-transfer sequencer.
package rtc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WP_CLR = 3'd1,
    ST_XFER   = 3'd2,
    ST_WP_SET = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [7:0] WP_ADDR_DEFAULT = 8'h8E;
  localparam logic [7:0] WP_CLEAR        = 8'h00;
  localparam logic [7:0] WP_SET          = 8'h80;

  localparam int unsigned REG_SEC   = 0;
  localparam int unsigned REG_MIN   = 1;
  localparam int unsigned REG_HOUR  = 2;
  localparam int unsigned REG_DATE  = 3;
  localparam int unsigned REG_MONTH = 4;
  localparam int unsigned REG_DAY   = 5;
  localparam int unsigned REG_YEAR  = 6;

endpackage

// File: rtl/rtc_reg_seq_if.sv
// Byte-level command engine handshake between the sequencer and the serial engine.
interface rtc_reg_seq_if;
  logic       cmd_read;
  logic       cmd_write;
  logic [7:0] read_addr;
  logic [7:0] write_addr;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       cmd_read_ack;
  logic       cmd_write_ack;

  modport master (
    output cmd_read, cmd_write, read_addr, write_addr, write_data,
    input  read_data, cmd_read_ack, cmd_write_ack
  );

  modport slave (
    input  cmd_read, cmd_write, read_addr, write_addr, write_data,
    output read_data, cmd_read_ack, cmd_write_ack
  );
endinterface

// File: rtl/rtc_mask_scan.sv
// Finds the next set mask bit above idx (or the lowest set bit when first_i).
module rtc_mask_scan #(
  parameter int unsigned NUM_REGS = 7,
  parameter int unsigned IDX_W    = 3
) (
  input  logic [NUM_REGS-1:0] mask_i,
  input  logic [IDX_W-1:0]    idx_i,
  input  logic                first_i,
  output logic [IDX_W-1:0]    nxt_o,
  output logic                last_o
);

  int start_c;

  assign start_c = first_i ? 0 : int'(idx_i) + 1;

  // Descending scan so the lowest qualifying bit wins; last_o = nothing left.
  always_comb begin
    nxt_o  = '0;
    last_o = 1'b1;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
      if (mask_i[i] && i >= start_c) begin
        nxt_o  = IDX_W'(i);
        last_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rtc_reg_seq.sv
// Masked burst of RTC register reads/writes with write-protect handling and timeout.
module rtc_reg_seq
  import rtc_pkg::*;
#(
  parameter int unsigned NUM_REGS       = REG_YEAR + 1,
  parameter logic [7:0]  ADDR_BASE      = 8'h80,
  parameter logic [7:0]  ADDR_STRIDE    = 8'd2,
  parameter logic [7:0]  WP_ADDR        = WP_ADDR_DEFAULT,
  parameter bit          WP_RESTORE     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  req_write,
  input  logic [NUM_REGS-1:0]   reg_mask,
  input  logic [NUM_REGS*8-1:0] wr_regs,
  output logic [NUM_REGS*8-1:0] rd_regs,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  rtc_reg_seq_if.master         bus
);

  localparam int unsigned IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 2);

  state_t                     state_q;
  logic                       write_q;
  logic [NUM_REGS-1:0]        mask_q;
  logic [NUM_REGS-1:0][7:0]   wdata_q;
  logic [NUM_REGS-1:0][7:0]   rd_q;
  logic [IDX_W-1:0]           idx_q;
  logic [TMO_W-1:0]           tmo_q;
  logic                       busy_q, done_q, err_q;
  logic                       cmd_read_q, cmd_write_q;
  logic [7:0]                 read_addr_q, write_addr_q, write_data_q;

  logic [NUM_REGS-1:0][7:0]   wr_in_c;
  logic [NUM_REGS-1:0]        scan_mask_c;
  logic                       scan_first_c;
  logic [IDX_W-1:0]           scan_nxt_c;
  logic                       scan_last_c;
  logic [7:0]                 nxt_addr_c;
  logic                       cmd_on_c, ack_c, tmo_hit_c;

  function automatic logic [7:0] reg_addr(input logic [IDX_W-1:0] idx);
    return ADDR_BASE + 8'(idx) * ADDR_STRIDE;
  endfunction

  assign wr_in_c      = wr_regs;
  assign scan_mask_c  = (state_q == ST_IDLE) ? reg_mask : mask_q;
  assign scan_first_c = (state_q == ST_IDLE) || (state_q == ST_WP_CLR);
  assign nxt_addr_c   = reg_addr(scan_nxt_c);
  assign cmd_on_c     = cmd_read_q | cmd_write_q;
  assign ack_c        = (cmd_read_q & bus.cmd_read_ack) | (cmd_write_q & bus.cmd_write_ack);
  assign tmo_hit_c    = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES));

  rtc_mask_scan #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) u_scan (
    .mask_i  (scan_mask_c),
    .idx_i   (idx_q),
    .first_i (scan_first_c),
    .nxt_o   (scan_nxt_c),
    .last_o  (scan_last_c)
  );

  // Sequencer FSM: each step presents address/data for one cycle, then holds the command until ack or timeout.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      mask_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cmd_read_q   <= 1'b0;
      cmd_write_q  <= 1'b0;
      read_addr_q  <= '0;
      write_addr_q <= '0;
      write_data_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            write_q <= req_write;
            mask_q  <= reg_mask;
            wdata_q <= wr_in_c;
            busy_q  <= 1'b1;
            err_q   <= 1'b0;
            if (reg_mask == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else if (req_write) begin
              state_q      <= ST_WP_CLR;
              write_addr_q <= WP_ADDR;
              write_data_q <= WP_CLEAR;
            end else begin
              state_q     <= ST_XFER;
              idx_q       <= scan_nxt_c;
              read_addr_q <= nxt_addr_c | 8'h01;
            end
          end
        end

        ST_WP_CLR, ST_XFER, ST_WP_SET: begin
          if (!cmd_on_c) begin
            if (state_q == ST_XFER && !write_q) cmd_read_q <= 1'b1;
            else                                cmd_write_q <= 1'b1;
            tmo_q <= TMO_W'(1);
          end else if (ack_c) begin
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
            case (state_q)
              ST_WP_CLR: begin
                state_q      <= ST_XFER;
                idx_q        <= scan_nxt_c;
                write_addr_q <= nxt_addr_c;
                write_data_q <= wdata_q[scan_nxt_c];
              end
              ST_XFER: begin
                if (!write_q) rd_q[idx_q] <= bus.read_data;
                if (scan_last_c) begin
                  if (write_q && WP_RESTORE) begin
                    state_q      <= ST_WP_SET;
                    write_addr_q <= WP_ADDR;
                    write_data_q <= WP_SET;
                  end else begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                  end
                end else begin
                  idx_q <= scan_nxt_c;
                  if (write_q) begin
                    write_addr_q <= nxt_addr_c;
                    write_data_q <= wdata_q[scan_nxt_c];
                  end else begin
                    read_addr_q <= nxt_addr_c | 8'h01;
                  end
                end
              end
              default: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            endcase
          end else if (tmo_hit_c) begin
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            read_addr_q  <= '0;
            write_addr_q <= '0;
            write_data_q <= '0;
            err_q        <= 1'b1;
            done_q       <= 1'b1;
            state_q      <= ST_DONE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end

        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rd_regs        = rd_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign bus.cmd_read   = cmd_read_q;
  assign bus.cmd_write  = cmd_write_q;
  assign bus.read_addr  = read_addr_q;
  assign bus.write_addr = write_addr_q;
  assign bus.write_data = write_data_q;

endmodule

// File: tb/tb_rtc_reg_seq.sv
// Randomized self-checking bench for rtc_reg_seq with a command-list reference model.
module tb_rtc_reg_seq;
  import rtc_pkg::*;

  typedef logic [16:0] ent_t;  // {is_write, addr, data}

  logic sys_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Main instance: WP restore on, short timeout
  logic        req = 1'b0, req_write = 1'b0;
  logic [6:0]  reg_mask = '0;
  logic [55:0] wr_regs = '0, rd_regs;
  logic        busy, done, err;
  rtc_reg_seq_if a_if ();

  rtc_reg_seq #(.TIMEOUT_CYCLES(16)) u_dut (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_write (req_write),
    .reg_mask  (reg_mask),
    .wr_regs   (wr_regs),
    .rd_regs   (rd_regs),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus       (a_if)
  );

  // Second instance: no WP restore
  logic        b_req = 1'b0, b_req_write = 1'b0;
  logic [6:0]  b_reg_mask = '0;
  logic [55:0] b_wr_regs = '0, b_rd_regs;
  logic        b_busy, b_done, b_err;
  rtc_reg_seq_if b_if ();

  rtc_reg_seq #(.WP_RESTORE(1'b0), .TIMEOUT_CYCLES(16)) u_dut_nr (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .req       (b_req),
    .req_write (b_req_write),
    .reg_mask  (b_reg_mask),
    .wr_regs   (b_wr_regs),
    .rd_regs   (b_rd_regs),
    .busy      (b_busy),
    .done      (b_done),
    .err       (b_err),
    .bus       (b_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Command engine model for the main instance
  logic [7:0] salt = 8'h11;
  bit         withhold = 1'b0;
  bit         a_given = 1'b0;
  int         a_wait = 0, a_lat = 0;

  function automatic logic [7:0] rd_value(input logic [7:0] addr);
    return salt + 8'((addr - 8'h81) >> 1);
  endfunction

  initial begin
    a_if.cmd_read_ack = 1'b0; a_if.cmd_write_ack = 1'b0; a_if.read_data = 8'h00;
    b_if.cmd_read_ack = 1'b0; b_if.cmd_write_ack = 1'b0; b_if.read_data = 8'h00;
  end

  always @(negedge sys_clk) begin
    a_if.cmd_read_ack  = 1'b0;
    a_if.cmd_write_ack = 1'b0;
    a_if.read_data     = 8'($urandom);
    if (a_if.cmd_read || a_if.cmd_write) begin
      if (!a_given) begin
        if (!withhold && a_wait >= a_lat) begin
          a_given = 1'b1;
          if (a_if.cmd_read) begin
            a_if.cmd_read_ack = 1'b1;
            a_if.read_data    = rd_value(a_if.read_addr);
          end else begin
            a_if.cmd_write_ack = 1'b1;
          end
        end else begin
          a_wait++;
          if ($urandom_range(0, 3) == 0) begin
            if (a_if.cmd_read) a_if.cmd_write_ack = 1'b1;
            else               a_if.cmd_read_ack  = 1'b1;
          end
        end
      end
    end else begin
      a_given = 1'b0;
      a_wait  = 0;
      a_lat   = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 1) a_if.cmd_read_ack  = 1'b1;
        else                           a_if.cmd_write_ack = 1'b1;
      end
    end
  end

  // Bus monitor for the main instance: logs commands and counts protocol violations
  ent_t       a_log[$];
  int         viol = 0, hi_len = 0, last_hi = 0, low_len = 0;
  bit         prev_cmd = 1'b0, seen_fall = 1'b0, cmd_now;
  logic [7:0] cap_ra, cap_wa, cap_wd;

  always @(negedge sys_clk) begin
    cmd_now = a_if.cmd_read | a_if.cmd_write;
    if (a_if.cmd_read && a_if.cmd_write) viol++;
    if (cmd_now && !prev_cmd) begin
      a_log.push_back({a_if.cmd_write, a_if.cmd_write ? a_if.write_addr : a_if.read_addr, a_if.write_data});
      cap_ra = a_if.read_addr; cap_wa = a_if.write_addr; cap_wd = a_if.write_data;
      hi_len = 1;
      if (seen_fall && low_len != 1) viol++;
    end else if (cmd_now) begin
      hi_len++;
      if (a_if.read_addr != cap_ra || a_if.write_addr != cap_wa || a_if.write_data != cap_wd) viol++;
    end else if (prev_cmd) begin
      last_hi   = hi_len;
      seen_fall = 1'b1;
      low_len   = 1;
    end else begin
      low_len++;
    end
    if (a_if.cmd_read && (a_if.write_addr != 8'h00 || a_if.write_data != 8'h00)) viol++;
    if (a_if.cmd_write && a_if.read_addr != 8'h00) viol++;
    if (!busy && (a_if.read_addr != 8'h00 || a_if.write_addr != 8'h00 || a_if.write_data != 8'h00 || cmd_now)) viol++;
    if (!busy) seen_fall = 1'b0;
    prev_cmd = cmd_now;
  end

  // Second instance: immediate acks and a plain command log
  ent_t b_log[$];
  bit   b_given = 1'b0, b_prev = 1'b0;

  always @(negedge sys_clk) begin
    b_if.cmd_read_ack  = 1'b0;
    b_if.cmd_write_ack = 1'b0;
    if (!(b_if.cmd_read || b_if.cmd_write)) begin
      b_given = 1'b0;
    end else if (!b_given) begin
      b_given = 1'b1;
      if (b_if.cmd_write) b_if.cmd_write_ack = 1'b1;
      else                b_if.cmd_read_ack  = 1'b1;
    end
    if ((b_if.cmd_read || b_if.cmd_write) && !b_prev)
      b_log.push_back({b_if.cmd_write, b_if.cmd_write ? b_if.write_addr : b_if.read_addr, b_if.write_data});
    b_prev = b_if.cmd_read | b_if.cmd_write;
  end

  // Reference: rd_regs contents the bench expects after every completed burst
  logic [55:0] model_rd = '0;

  task automatic run_burst(input logic wr, input logic [6:0] m, input logic [55:0] wv, input bit exp_tmo);
    ent_t exp_q[$];
    int   first_k, done_k;
    logic err_at_done, busy_at_done;
    first_k = -1; done_k = -1; err_at_done = 1'b0; busy_at_done = 1'b0;
    if (m != 7'd0) begin
      if (wr) exp_q.push_back({1'b1, 8'h8E, 8'h00});
      for (int i = 0; i < 7; i++) begin
        if (m[i]) begin
          if (wr) exp_q.push_back({1'b1, 8'(8'h80 + 2 * i), wv[8*i +: 8]});
          else    exp_q.push_back({1'b0, 8'(8'h81 + 2 * i), 8'h00});
        end
      end
      if (wr) exp_q.push_back({1'b1, 8'h8E, 8'h80});
    end
    if (exp_tmo) while (exp_q.size() > 1) void'(exp_q.pop_back());

    @(negedge sys_clk);
    a_log.delete();
    viol      = 0;
    req       = 1'b1;
    req_write = wr;
    reg_mask  = m;
    wr_regs   = wv;
    for (int k = 1; k <= 400; k++) begin
      @(negedge sys_clk);
      if (k == 1) begin
        req = 1'b0;
        chk("busy_c1", 64'(busy), 64'd1);
        req_write = 1'($urandom);
        reg_mask  = 7'($urandom);
        wr_regs   = 56'({$urandom, $urandom});
      end
      if ((a_if.cmd_read || a_if.cmd_write) && first_k < 0) first_k = k;
      if (done) begin
        done_k = k; err_at_done = err; busy_at_done = busy;
        break;
      end
      req = (k == 3) && ($urandom_range(0, 1) == 1);
    end
    req = 1'b0;
    chk("done_seen", 64'(done_k >= 0), 64'd1);
    chk("first_cmd", 64'(first_k), (m == 7'd0) ? 64'(-1) : 64'd2);
    if (m == 7'd0) chk("mask0_done_c1", 64'(done_k), 64'd1);
    chk("err_at_done", 64'(err_at_done), 64'(exp_tmo));
    chk("busy_at_done", 64'(busy_at_done), 64'd1);
    @(negedge sys_clk);
    chk("done_pulse", 64'({busy, done}), 64'd0);
    chk("err_hold", 64'(err), 64'(exp_tmo));
    if (exp_tmo) chk("tmo_len", 64'(last_hi), 64'd16);
    chk("n_cmds", 64'(a_log.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < a_log.size()) chk($sformatf("cmd%0d", i), 64'(a_log[i]), 64'(exp_q[i]));
    if (!wr && !exp_tmo)
      for (int i = 0; i < 7; i++) if (m[i]) model_rd[8*i +: 8] = salt + 8'(i);
    chk("rd_regs", 64'(rd_regs), 64'(model_rd));
    chk("bus_viol", 64'(viol), 64'd0);
  endtask

  initial begin
    int   seen;
    logic [55:0] wv;

    repeat (3) @(negedge sys_clk);
    chk("rst_ctrl", 64'({busy, done, err, a_if.cmd_read, a_if.cmd_write}), 64'd0);
    chk("rst_bus", 64'({a_if.read_addr, a_if.write_addr, a_if.write_data}), 64'd0);
    chk("rst_rd", 64'(rd_regs), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Full read burst with 8'h11+i returned
    salt = 8'h11;
    run_burst(1'b0, 7'h7F, 56'd0, 1'b0);
    chk("rd_sec",   64'(rd_regs[REG_SEC*8   +: 8]), 64'h11);
    chk("rd_min",   64'(rd_regs[REG_MIN*8   +: 8]), 64'h12);
    chk("rd_hour",  64'(rd_regs[REG_HOUR*8  +: 8]), 64'h13);
    chk("rd_date",  64'(rd_regs[REG_DATE*8  +: 8]), 64'h14);
    chk("rd_month", 64'(rd_regs[REG_MONTH*8 +: 8]), 64'h15);
    chk("rd_day",   64'(rd_regs[REG_DAY*8   +: 8]), 64'h16);
    chk("rd_year",  64'(rd_regs[REG_YEAR*8  +: 8]), 64'h17);

    // Write sec and hour
    wv = '0;
    wv[REG_SEC*8 +: 8]  = 8'h30;
    wv[REG_HOUR*8 +: 8] = 8'h12;
    run_burst(1'b1, 7'b0000101, wv, 1'b0);

    // Empty mask
    run_burst(1'b0, 7'd0, 56'd0, 1'b0);
    run_burst(1'b1, 7'd0, 56'd0, 1'b0);

    // Randomized bursts
    for (int n = 0; n < 24; n++) begin
      salt = 8'($urandom);
      case ($urandom_range(0, 5))
        0:       run_burst(1'($urandom), 7'h7F, 56'({$urandom, $urandom}), 1'b0);
        1:       run_burst(1'($urandom), 7'h40, 56'({$urandom, $urandom}), 1'b0);
        default: run_burst(1'($urandom), 7'($urandom), 56'({$urandom, $urandom}), 1'b0);
      endcase
    end

    // Withheld acks: write aborts in WP_CLR, read aborts on the first register
    withhold = 1'b1;
    run_burst(1'b1, 7'h01, 56'({$urandom, $urandom}), 1'b1);
    run_burst(1'b0, 7'h06, 56'd0, 1'b1);
    withhold = 1'b0;
    run_burst(1'b0, 7'd0, 56'd0, 1'b0);

    // Reset while a write command is outstanding
    withhold = 1'b1;
    @(negedge sys_clk);
    req = 1'b1; req_write = 1'b1; reg_mask = 7'h7F;
    @(negedge sys_clk);
    req = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (a_if.cmd_write) begin seen = 1; break; end
      @(negedge sys_clk);
    end
    chk("rst_cmd_up", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", 64'({busy, done, err, a_if.cmd_read, a_if.cmd_write}), 64'd0);
    chk("rst_mid_bus", 64'({a_if.read_addr, a_if.write_addr, a_if.write_data}), 64'd0);
    chk("rst_mid_rd", 64'(rd_regs), 64'd0);
    @(negedge sys_clk);
    rst_n    = 1'b1;
    withhold = 1'b0;
    model_rd = '0;
    salt     = 8'($urandom);
    run_burst(1'b0, 7'h2B, 56'd0, 1'b0);
    run_burst(1'b1, 7'h11, 56'({$urandom, $urandom}), 1'b0);

    // No-restore instance: single-register write skips WP_SET
    b_log.delete();
    @(negedge sys_clk);
    b_req = 1'b1; b_req_write = 1'b1; b_reg_mask = 7'h01; b_wr_regs = 56'h5A;
    @(negedge sys_clk);
    b_req = 1'b0;
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (b_done) begin seen = 1; break; end
      @(negedge sys_clk);
    end
    chk("nr_done", 64'(seen), 64'd1);
    chk("nr_err", 64'(b_err), 64'd0);
    @(negedge sys_clk);
    chk("nr_idle", 64'({b_busy, b_done}), 64'd0);
    chk("nr_n_cmds", 64'(b_log.size()), 64'd2);
    if (b_log.size() == 2) begin
      chk("nr_cmd0", 64'(b_log[0]), 64'({1'b1, 8'h8E, 8'h00}));
      chk("nr_cmd1", 64'(b_log[1]), 64'({1'b1, 8'h80, 8'h5A}));
    end
    chk("nr_rd", 64'(b_rd_regs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
